// File: rtl/canny_frame_ctrl.sv
// Frame gate in front of the canny edge pipeline: passes whole camera frames only, latches
// per-frame thresholds, tracks frames still inside the pipeline and flags line/frame timing errors.
module canny_frame_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  gray_data,
    input  logic        gray_hs,
    input  logic        gray_vs,
    input  logic        gray_de,
    input  logic        NMS_vs,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_wdata,
    output logic [7:0]  pipe_data,
    output logic        pipe_hs,
    output logic        pipe_vs,
    output logic        pipe_de,
    output logic [7:0]  th_high,
    output logic [7:0]  th_low,
    output logic [15:0] frame_cnt,
    output logic        pix_err,
    output logic        line_err,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {StIdle, StWaitVs, StRun, StDrain} state_e;

    localparam logic [11:0] CntMax = 12'hFFF;

    state_e      state_q, state_d;
    logic        enable_q, enable_d;
    logic [7:0]  th_high_req_q, th_high_req_d;
    logic [7:0]  th_low_req_q, th_low_req_d;
    logic [7:0]  th_high_q, th_high_d;
    logic [7:0]  th_low_q, th_low_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]  inflight_q, inflight_d;
    logic [11:0] pix_cnt_q, pix_cnt_d;
    logic [11:0] line_cnt_q, line_cnt_d;
    logic [7:0]  pipe_data_q, pipe_data_d;
    logic        pipe_hs_q, pipe_hs_d;
    logic        pipe_vs_q, pipe_vs_d;
    logic        pipe_de_q, pipe_de_d;
    logic        gray_vs_q, gray_de_q, nms_vs_q;
    logic        pix_err_q, pix_err_d;
    logic        line_err_q, line_err_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;

    logic vs_rise, vs_fall, de_fall, nms_fall, pv_rise;
    logic ctrl_wr, err_clr, enter_run, in_run, pass, pix_set, line_set;

    always_comb begin
        vs_rise   = gray_vs & ~gray_vs_q;
        vs_fall   = ~gray_vs & gray_vs_q;
        de_fall   = ~gray_de & gray_de_q;
        nms_fall  = ~NMS_vs & nms_vs_q;
        ctrl_wr   = cfg_we && (cfg_addr == 2'd0);
        err_clr   = ctrl_wr && cfg_wdata[1];
        in_run    = (state_q == StRun);
        enter_run = (state_q == StWaitVs) && enable_q && vs_rise;
        pass      = in_run || enter_run;

        enable_d      = ctrl_wr ? cfg_wdata[0] : enable_q;
        th_high_req_d = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : th_high_req_q;
        th_low_req_d  = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : th_low_req_q;

        state_d = state_q;
        unique case (state_q)
            StIdle:   if (enable_q) state_d = StWaitVs;
            StWaitVs: begin
                if (!enable_q)    state_d = StIdle;
                else if (vs_rise) state_d = StRun;
            end
            StRun:    if (vs_fall) state_d = enable_q ? StWaitVs : StDrain;
            StDrain:  if (inflight_q == 2'd0) state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        pipe_data_d = pass ? gray_data : 8'd0;
        pipe_hs_d   = pass & gray_hs;
        pipe_vs_d   = pass & gray_vs;
        pipe_de_d   = pass & gray_de;

        // Thresholds are sampled once per frame so the pipeline never sees a mid-frame change.
        th_high_d   = th_high_q;
        th_low_d    = th_low_q;
        frame_cnt_d = frame_cnt_q;
        if (enter_run) begin
            th_high_d   = th_high_req_q;
            th_low_d    = (th_low_req_q > th_high_req_q) ? th_high_req_q : th_low_req_q;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        pv_rise    = pipe_vs_d & ~pipe_vs_q;
        inflight_d = inflight_q;
        if (pv_rise && !nms_fall && inflight_q != 2'd3) begin
            inflight_d = inflight_q + 2'd1;
        end else if (nms_fall && !pv_rise && inflight_q != 2'd0) begin
            inflight_d = inflight_q - 2'd1;
        end
        frame_done_d = nms_fall && (inflight_q != 2'd0);
        busy_d       = (state_d == StRun) || (inflight_d != 2'd0);

        pix_cnt_d = pix_cnt_q;
        if (enter_run || (in_run && de_fall)) begin
            pix_cnt_d = 12'd0;
        end else if (in_run && gray_de && pix_cnt_q != CntMax) begin
            pix_cnt_d = pix_cnt_q + 12'd1;
        end

        line_cnt_d = line_cnt_q;
        if (enter_run) begin
            line_cnt_d = 12'd0;
        end else if (in_run && de_fall && line_cnt_q != CntMax) begin
            line_cnt_d = line_cnt_q + 12'd1;
        end

        // line_cnt_d already includes a last line whose de fall coincides with the vs fall.
        pix_set  = in_run && de_fall && (pix_cnt_q != 12'(H_ACTIVE));
        line_set = in_run && vs_fall && (line_cnt_d != 12'(V_ACTIVE));
        pix_err_d  = (pix_err_q & ~err_clr) | pix_set;
        line_err_d = (line_err_q & ~err_clr) | line_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            enable_q      <= 1'b0;
            th_high_req_q <= 8'd0;
            th_low_req_q  <= 8'd0;
            th_high_q     <= 8'd0;
            th_low_q      <= 8'd0;
            frame_cnt_q   <= 16'd0;
            inflight_q    <= 2'd0;
            pix_cnt_q     <= 12'd0;
            line_cnt_q    <= 12'd0;
            pipe_data_q   <= 8'd0;
            pipe_hs_q     <= 1'b0;
            pipe_vs_q     <= 1'b0;
            pipe_de_q     <= 1'b0;
            gray_vs_q     <= 1'b0;
            gray_de_q     <= 1'b0;
            nms_vs_q      <= 1'b0;
            pix_err_q     <= 1'b0;
            line_err_q    <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            enable_q      <= enable_d;
            th_high_req_q <= th_high_req_d;
            th_low_req_q  <= th_low_req_d;
            th_high_q     <= th_high_d;
            th_low_q      <= th_low_d;
            frame_cnt_q   <= frame_cnt_d;
            inflight_q    <= inflight_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            pipe_data_q   <= pipe_data_d;
            pipe_hs_q     <= pipe_hs_d;
            pipe_vs_q     <= pipe_vs_d;
            pipe_de_q     <= pipe_de_d;
            gray_vs_q     <= gray_vs;
            gray_de_q     <= gray_de;
            nms_vs_q      <= NMS_vs;
            pix_err_q     <= pix_err_d;
            line_err_q    <= line_err_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign pipe_data  = pipe_data_q;
    assign pipe_hs    = pipe_hs_q;
    assign pipe_vs    = pipe_vs_q;
    assign pipe_de    = pipe_de_q;
    assign th_high    = th_high_q;
    assign th_low     = th_low_q;
    assign frame_cnt  = frame_cnt_q;
    assign pix_err    = pix_err_q;
    assign line_err   = line_err_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Scoreboard bench for canny_frame_ctrl: a frame-level model predicts the gated stream and
// status outputs; a negedge monitor compares each prediction one clock after it was issued.
module tb_canny_frame_ctrl;

    localparam int H = 16;
    localparam int V = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  gray_data;
    logic        gray_hs, gray_vs, gray_de;
    bit          nms_vs;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic [7:0]  pipe_data;
    logic        pipe_hs, pipe_vs, pipe_de;
    logic [7:0]  th_high, th_low;
    logic [15:0] frame_cnt;
    logic        pix_err, line_err, busy, frame_done;

    canny_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk(clk), .rst(rst),
        .gray_data(gray_data), .gray_hs(gray_hs), .gray_vs(gray_vs), .gray_de(gray_de),
        .NMS_vs(nms_vs),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .pipe_data(pipe_data), .pipe_hs(pipe_hs), .pipe_vs(pipe_vs), .pipe_de(pipe_de),
        .th_high(th_high), .th_low(th_low), .frame_cnt(frame_cnt),
        .pix_err(pix_err), .line_err(line_err), .busy(busy), .frame_done(frame_done)
    );

    // Edge pipeline stand-in: NMS_vs is pipe_vs delayed by nms_delay cycles.
    bit         hist [4096];
    logic [11:0] wp = 12'd0;
    logic [11:0] nms_delay = 12'd20;
    always @(negedge clk) begin
        hist[wp] <= pipe_vs;
        nms_vs   <= hist[wp - nms_delay];
        wp       <= wp + 12'd1;
    end

    int pcnt = 0;
    always @(posedge clk) pcnt <= pcnt + 1;

    typedef struct packed {
        int         tag;
        logic       vs;
        logic       hs;
        logic       de;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        int          tag;
        int          kind;
        logic [15:0] val;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    // Frame-level reference model.
    logic        m_enable, m_run, m_prev_vs, m_prev_de, m_pix_err, m_line_err;
    logic [7:0]  m_thh_req, m_thl_req, m_thh, m_thl;
    logic [15:0] m_frames;
    int          m_pixels, m_lines, m_done;

    function automatic string kind_name(input int k);
        case (k)
            0: return "th_high";
            1: return "th_low";
            2: return "frame_cnt";
            3: return "pix_err";
            4: return "line_err";
            5: return "busy";
            default: return "frame_done_count";
        endcase
    endfunction

    always @(negedge clk) begin
        logic [15:0] act;
        exp_t e;
        req_t r;
        if (frame_done === 1'b1) done_cnt = done_cnt + 1;
        if (exp_q.size() > 0 && exp_q[0].tag <= pcnt - 1) begin
            e = exp_q.pop_front();
            checks = checks + 1;
            if ({pipe_vs, pipe_hs, pipe_de, pipe_data} !== {e.vs, e.hs, e.de, e.data}) begin
                errors = errors + 1;
                $display("FAIL pipe_stream cycle %0d: got vs/hs/de/data=%b/%b/%b/%h want %b/%b/%b/%h",
                         e.tag, pipe_vs, pipe_hs, pipe_de, pipe_data, e.vs, e.hs, e.de, e.data);
            end
        end else if (pipe_de !== 1'b0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL pipe_unexpected cycle %0d: got pipe_de=%b want 0", pcnt, pipe_de);
        end
        while (req_q.size() > 0 && req_q[0].tag <= pcnt - 1) begin
            r = req_q.pop_front();
            case (r.kind)
                0: act = {8'd0, th_high};
                1: act = {8'd0, th_low};
                2: act = frame_cnt;
                3: act = {15'd0, pix_err};
                4: act = {15'd0, line_err};
                5: act = {15'd0, busy};
                default: act = done_cnt[15:0];
            endcase
            checks = checks + 1;
            if (act !== r.val) begin
                errors = errors + 1;
                $display("FAIL %s cycle %0d: got %0d want %0d", kind_name(r.kind), r.tag, act,
                         r.val);
            end
        end
    end

    task automatic expect_out(input int kind, input logic [15:0] val);
        req_t r;
        r.tag = pcnt; r.kind = kind; r.val = val;
        req_q.push_back(r);
    endtask

    task automatic expect_status();
        expect_out(0, {8'd0, m_thh});
        expect_out(1, {8'd0, m_thl});
        expect_out(2, m_frames);
        expect_out(3, {15'd0, m_pix_err});
        expect_out(4, {15'd0, m_line_err});
    endtask

    task automatic step(input logic vs, input logic hs, input logic de, input logic [7:0] d,
                        input logic we, input logic [1:0] a, input logic [7:0] w,
                        input logic r);
        exp_t e;
        @(posedge clk);
        #1;
        gray_vs = vs; gray_hs = hs; gray_de = de; gray_data = d;
        cfg_we = we; cfg_addr = a; cfg_wdata = w; rst = r;
        e.tag = pcnt;
        if (r) begin
            m_enable = 0; m_run = 0; m_pix_err = 0; m_line_err = 0;
            m_thh_req = 0; m_thl_req = 0; m_thh = 0; m_thl = 0; m_frames = 0;
            e.vs = 0; e.hs = 0; e.de = 0; e.data = 0;
            exp_q.push_back(e);
        end else begin
            if (vs && !m_prev_vs && m_enable) begin
                m_run = 1; m_lines = 0; m_pixels = 0;
                m_thh = m_thh_req;
                m_thl = (m_thl_req > m_thh_req) ? m_thh_req : m_thl_req;
                m_frames = m_frames + 16'd1;
            end
            e.vs = m_run & vs; e.hs = m_run & hs; e.de = m_run & de;
            e.data = m_run ? d : 8'd0;
            exp_q.push_back(e);
            if (we && a == 2'd0 && w[1]) begin
                m_pix_err = 0; m_line_err = 0;
            end
            if (m_run && de) m_pixels++;
            if (m_run && !de && m_prev_de) begin
                if (m_pixels != H) m_pix_err = 1;
                m_pixels = 0;
                m_lines++;
            end
            if (m_run && !vs && m_prev_vs) begin
                if (m_lines != V) m_line_err = 1;
                m_done++;
                m_run = 0;
            end
            if (we) begin
                case (a)
                    2'd0: m_enable = w[0];
                    2'd1: m_thh_req = w;
                    2'd2: m_thl_req = w;
                    default: ;
                endcase
            end
        end
        m_prev_vs = vs;
        m_prev_de = de;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'd0, 0, 2'd0, 8'd0, 0);
    endtask

    task automatic cfg(input logic [1:0] a, input logic [7:0] w);
        step(0, 0, 0, 8'd0, 1, a, w, 0);
    endtask

    // act: 1 enable, 2 th_high=200, 3 disable, 4 reset, 5 error clear (enable kept)
    task automatic frame(input int n_lines, input int short_line, input int act,
                         input int act_line, input int act_pos);
        logic we, r, hit;
        logic [1:0] a;
        logic [7:0] w;
        int len;
        idle(6);
        step(1, 0, 0, 8'($urandom), 0, 2'd0, 8'd0, 0);
        for (int i = 0; i < 2; i++) step(1, 0, 0, 8'($urandom), 0, 2'd0, 8'd0, 0);
        for (int l = 0; l < n_lines; l++) begin
            len = (l == short_line) ? H - 1 : H;
            for (int p = 0; p < len + 4; p++) begin
                hit = (l == act_line) && (p == act_pos);
                we = 0; a = 2'd0; w = 8'd0; r = 0;
                if (hit) begin
                    case (act)
                        1: begin we = 1; w = 8'd1; end
                        2: begin we = 1; a = 2'd1; w = 8'd200; end
                        3: begin we = 1; w = 8'd0; end
                        4: r = 1;
                        5: begin we = 1; w = 8'd3; end
                        default: ;
                    endcase
                end
                step(1, (p >= len) && (p < len + 2), p < len, 8'($urandom), we, a, w, r);
                if (hit && act == 4) begin
                    expect_status();
                    expect_out(5, 16'd0);
                end
            end
        end
        for (int i = 0; i < 2; i++) step(1, 0, 0, 8'($urandom), 0, 2'd0, 8'd0, 0);
        step(0, 0, 0, 8'd0, 0, 2'd0, 8'd0, 0);
    endtask

    initial begin
        int waited;
        m_enable = 0; m_run = 0; m_prev_vs = 0; m_prev_de = 0; m_pix_err = 0; m_line_err = 0;
        m_thh_req = 0; m_thl_req = 0; m_thh = 0; m_thl = 0; m_frames = 0;
        m_pixels = 0; m_lines = 0; m_done = 0;
        rst = 1; gray_vs = 0; gray_hs = 0; gray_de = 0; gray_data = 0;
        cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;

        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'd0, 0, 2'd0, 8'd0, 1);
        expect_status();
        expect_out(5, 16'd0);
        idle(5);
        frame(V, -1, 0, 0, 0);

        cfg(2'd1, 8'd80); cfg(2'd2, 8'd40); cfg(2'd0, 8'd1);
        frame(V, -1, 0, 0, 0);
        idle(40);
        expect_status();

        // enable arriving mid-frame only takes effect at the next frame start
        cfg(2'd0, 8'd0); idle(5);
        frame(V, -1, 1, 3, 5);
        frame(V, -1, 0, 0, 0);
        idle(40);
        expect_status();

        frame(V, -1, 2, 4, 0);
        idle(10);
        expect_out(0, {8'd0, m_thh});
        frame(V, -1, 0, 0, 0);
        idle(10);
        expect_out(0, {8'd0, m_thh});
        cfg(2'd1, 8'd50); cfg(2'd2, 8'd90);
        frame(V, -1, 0, 0, 0);
        idle(10);
        expect_status();

        frame(V, 2, 0, 0, 0);
        idle(10);
        expect_status();
        frame(V - 1, -1, 0, 0, 0);
        idle(10);
        expect_status();
        cfg(2'd0, 8'd3); idle(2);
        expect_status();
        frame(V, 5, 5, 5, H - 1);
        idle(10);
        expect_status();

        // disable mid-frame with a long pipeline return
        idle(2100);
        nms_delay = 12'd2000;
        frame(V, -1, 3, 4, 0);
        idle(10);
        expect_out(5, 16'd1);
        expect_out(6, 16'(m_done - 1));
        idle(1500);
        expect_out(5, 16'd1);
        expect_out(6, 16'(m_done - 1));
        waited = 0;
        while (busy !== 1'b0 && waited < 1500) begin
            idle(1);
            waited++;
        end
        idle(3);
        expect_out(5, 16'd0);
        expect_out(6, 16'(m_done));
        frame(V, -1, 0, 0, 0);
        idle(10);
        nms_delay = 12'd20;

        cfg(2'd0, 8'd1); idle(5);
        frame(V, -1, 4, 3, 5);
        frame(V, -1, 0, 0, 0);
        idle(10);
        expect_status();
        cfg(2'd1, 8'd120); cfg(2'd0, 8'd1);
        frame(V, -1, 0, 0, 0);
        idle(10);
        expect_status();

        for (int k = 0; k < 3; k++) begin
            cfg(2'd1, 8'($urandom));
            cfg(2'd2, 8'($urandom));
            frame(V, -1, 0, 0, 0);
            idle(5);
            expect_status();
        end

        idle(100);
        expect_out(5, 16'd0);
        expect_out(6, 16'(m_done));
        idle(3);
        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
